// File: rtl/frame_pkg.sv
// Shared types and constants for the frame transmitter.
package frame_pkg;

  localparam logic [31:0] SYNC_WORD = 32'hABCDEFAB;
  localparam int unsigned SYNC_LEN  = 4;
  localparam int unsigned CNT_W     = 10;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    PAYLOAD
  } state_e;

  // Selects sync byte idx, most significant byte first.
  function automatic logic [7:0] sync_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[{2'd3 - idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/frame_byte_counter.sv
// Payload byte counter: clears on load, counts 0..limit-1 while enabled, flags the last count.
module frame_byte_counter
  import frame_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;

  assign tc_o = (cnt_q == limit_i - CNT_W'(1));

  // Returns to zero on terminal count so the value never exceeds limit-1.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || load_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tc_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/frame_transmitter.sv
// Frame transmitter: 4-byte sync word followed by n*4 payload bytes on a registered byte stream.
// Optional FRAME_TX_UNDERRUN_CNT_EN adds a saturating missing-byte counter output.
module frame_transmitter
  import frame_pkg::*;
#(
  parameter logic [31:0] SEQUENCE  = SYNC_WORD,
  parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] n,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       busy,
  output logic       done,
  output logic       underrun
`ifdef FRAME_TX_UNDERRUN_CNT_EN
  ,
  output logic [7:0] underrun_cnt
`endif
);

  state_e     state_q;
  logic [7:0] n_q;
  logic [1:0] sync_idx_q;
  logic [7:0] out_q;
  logic       out_valid_q;
  logic       busy_q;
  logic       done_q;
  logic       underrun_q;
  logic       din_ready_q;
  logic       tc;
  logic       accept;
  logic       last_sync;
  logic       miss;

  assign last_sync = (state_q == SYNC) && (sync_idx_q == 2'(SYNC_LEN - 1));
  assign miss      = (state_q == PAYLOAD) && !din_valid;
  // A new frame is taken from idle or on the final payload cycle (back-to-back).
  assign accept    = start && (n != 8'd0) &&
                     ((state_q == IDLE) || ((state_q == PAYLOAD) && tc));

  frame_byte_counter u_byte_cnt (
    .clk_i   (clk),
    .rst_n_i (rst),
    .load_i  (state_q != PAYLOAD),
    .en_i    (state_q == PAYLOAD),
    .limit_i ({n_q, 2'b00}),
    .tc_o    (tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      sync_idx_q  <= '0;
      out_q       <= IDLE_BYTE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      din_ready_q <= 1'b0;
    end else begin
      out_q       <= IDLE_BYTE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      din_ready_q <= 1'b0;
      // A miss on the last byte of a frame stays visible even if the next frame starts.
      if (miss) begin
        underrun_q <= 1'b1;
      end else if (accept) begin
        underrun_q <= 1'b0;
      end
      case (state_q)
        SYNC: begin
          out_q       <= sync_byte(SEQUENCE, sync_idx_q);
          out_valid_q <= 1'b1;
          busy_q      <= 1'b1;
          sync_idx_q  <= sync_idx_q + 2'd1;
          if (last_sync) begin
            state_q     <= PAYLOAD;
            din_ready_q <= 1'b1;
          end
        end
        PAYLOAD: begin
          out_q       <= din_valid ? din : IDLE_BYTE;
          out_valid_q <= 1'b1;
          busy_q      <= 1'b1;
          din_ready_q <= !tc;
          if (tc) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (accept) begin
        state_q    <= SYNC;
        n_q        <= n;
        sync_idx_q <= '0;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign underrun  = underrun_q;
  assign din_ready = din_ready_q;

`ifdef FRAME_TX_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      underrun_cnt_q <= '0;
    end else if (miss && (underrun_cnt_q != 8'hFF)) begin
      underrun_cnt_q <= underrun_cnt_q + 8'd1;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
`endif

endmodule
